// File: rtl/stopwatch_counter_if.sv
// Button inputs and BCD display outputs between the stopwatch core and its environment.
// The master side drives the raw button levels; the slave side is the timekeeping core.
interface stopwatch_counter_if;
   logic       start_stop;
   logic       lap;
   logic       clear;
   logic [3:0] digit_0;
   logic [3:0] digit_1;
   logic [3:0] digit_2;
   logic [3:0] digit_3;
   logic [3:0] digit_4;
   logic [3:0] digit_5;
   logic       running;
   logic       overflow;

   modport master (
      output start_stop, lap, clear,
      input  digit_0, digit_1, digit_2, digit_3, digit_4, digit_5,
      input  running, overflow
   );

   modport slave (
      input  start_stop, lap, clear,
      output digit_0, digit_1, digit_2, digit_3, digit_4, digit_5,
      output running, overflow
   );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS.hh stopwatch core: button edge detection, run/pause/lap/clear control,
// tick prescaler and a single-edge BCD cascade feeding registered display digits.
module stopwatch_counter #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 100
) (
   input logic                clock,
   input logic                reset,
   stopwatch_counter_if.slave bus
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, LAP_RUN, PAUSE} state_t;

   state_t           state_reg, state_next;
   logic [PW-1:0]    presc_reg, presc_next;
   logic [5:0][3:0]  count_reg, count_next;
   logic [5:0][3:0]  display_reg;
   logic             running_reg;
   logic             overflow_reg, overflow_next;
   logic             counting, tick, wrap, do_clear;

   logic [2:0] raw;
   logic [2:0] pulse;
   logic       ss_p, lap_p, clr_p;

   assign raw   = {bus.clear, bus.lap, bus.start_stop};
   assign ss_p  = pulse[0];
   assign lap_p = pulse[1];
   assign clr_p = pulse[2];

   // Two-stage synchronizer followed by a registered rising-edge detector per button.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         logic s1_reg, s2_reg, prev_reg, pulse_reg;
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               s1_reg    <= 1'b0;
               s2_reg    <= 1'b0;
               prev_reg  <= 1'b0;
               pulse_reg <= 1'b0;
            end else begin
               s1_reg    <= raw[gi];
               s2_reg    <= s1_reg;
               prev_reg  <= s2_reg;
               pulse_reg <= s2_reg & ~prev_reg;
            end
         end
         assign pulse[gi] = pulse_reg;
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      do_clear   = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (ss_p) state_next = RUN;
         end
         RUN: begin
            if (ss_p)       state_next = PAUSE;
            else if (lap_p) state_next = LAP_RUN;
         end
         LAP_RUN: begin
            if (ss_p)       state_next = PAUSE;
            else if (lap_p) state_next = RUN;
         end
         PAUSE: begin
            if (clr_p) begin
               state_next = IDLE;
               do_clear   = 1'b1;
            end else if (ss_p) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign counting = (state_reg == RUN) || (state_reg == LAP_RUN);
   assign tick     = counting && (presc_reg == PRESC_LAST);

   always_comb begin
      presc_next = presc_reg;
      if (do_clear)      presc_next = '0;
      else if (tick)     presc_next = '0;
      else if (counting) presc_next = presc_reg + 1'b1;
   end

   function automatic logic [3:0] digit_limit(input int idx);
      return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
   endfunction

   // Carry ripples through all six digits combinationally so the whole cascade lands on one edge.
   always_comb begin
      logic c;
      c          = tick;
      count_next = count_reg;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (count_reg[i] == digit_limit(i)) begin
               count_next[i] = 4'd0;
            end else begin
               count_next[i] = count_reg[i] + 4'd1;
               c             = 1'b0;
            end
         end
      end
      wrap = c;
      if (do_clear) count_next = '0;
   end

   always_comb begin
      overflow_next = overflow_reg | wrap;
      if (do_clear) overflow_next = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         presc_reg    <= '0;
         count_reg    <= '0;
         display_reg  <= '0;
         running_reg  <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         presc_reg    <= presc_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
         running_reg  <= (state_next == RUN) || (state_next == LAP_RUN);
         // The display keeps the snapshot only while staying in LAP_RUN.
         if (!(state_reg == LAP_RUN && state_next == LAP_RUN))
            display_reg <= count_next;
      end
   end

   assign bus.digit_0  = display_reg[0];
   assign bus.digit_1  = display_reg[1];
   assign bus.digit_2  = display_reg[2];
   assign bus.digit_3  = display_reg[3];
   assign bus.digit_4  = display_reg[4];
   assign bus.digit_5  = display_reg[5];
   assign bus.running  = running_reg;
   assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for the stopwatch core at DIV=10: latency, carries, wrap, lap freeze,
// pause/clear priority and held-button behaviour.
module tb_stopwatch_counter;
   logic clock;
   logic reset;
   int   total;
   int   bad;

   stopwatch_counter_if bus();

   stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("check %s got=%h", tag, got);
      end
   endtask

   function automatic logic [23:0] shown();
      return {bus.digit_5, bus.digit_4, bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0};
   endfunction

   task automatic wait_n(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Raises the chosen buttons; the action lands on the 4th rising edge, and the task
   // returns at the falling edge right after it.
   task automatic press(input logic ss, input logic lp, input logic cl);
      bus.start_stop = ss;
      bus.lap        = lp;
      bus.clear      = cl;
      wait_n(2);
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
      wait_n(2);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
      wait_n(3);
      reset = 1'b0;
      check("rst_digits", shown(), 24'h0);
      check("rst_running", {23'd0, bus.running}, 24'd0);

      // Reset asserted mid-count, between clock edges.
      press(1'b1, 1'b0, 1'b0);
      wait_n(30);
      #2 reset = 1'b1;
      #1;
      check("async_rst_digits", shown(), 24'h0);
      check("async_rst_running", {23'd0, bus.running}, 24'd0);
      check("async_rst_ovf", {23'd0, bus.overflow}, 24'd0);
      wait_n(2);
      reset = 1'b0;

      // Start latency and first tick.
      bus.start_stop = 1'b1;
      wait_n(2);
      bus.start_stop = 1'b0;
      wait_n(1);
      check("lat_edge_n2", {23'd0, bus.running}, 24'd0);
      wait_n(1);
      check("lat_edge_n3", {23'd0, bus.running}, 24'd1);
      wait_n(9);
      check("first_tick_m1", shown(), 24'h000000);
      wait_n(1);
      check("first_tick", shown(), 24'h000001);

      // Carries up to 00:10.00.
      wait_n(80);
      check("hund_9", shown(), 24'h000009);
      wait_n(10);
      check("hund_carry", shown(), 24'h000010);
      wait_n(9890);
      check("sec_999", shown(), 24'h000999);
      wait_n(10);
      check("ten_sec", shown(), 24'h001000);

      press(1'b1, 1'b0, 1'b0);
      check("pause_running", {23'd0, bus.running}, 24'd0);
      wait_n(20);
      check("pause_hold", shown(), 24'h001000);

      // 00:59.99 -> 01:00.00, resuming with a partial prescaler.
      force dut.count_reg = 24'h005999;
      wait_n(1);
      release dut.count_reg;
      wait_n(1);
      press(1'b1, 1'b0, 1'b0);
      wait_n(5);
      check("pre_min", shown(), 24'h005999);
      wait_n(1);
      check("min_carry", shown(), 24'h010000);

      // Full wrap past 59:59.99.
      press(1'b1, 1'b0, 1'b0);
      force dut.count_reg = 24'h595999;
      wait_n(1);
      release dut.count_reg;
      wait_n(1);
      press(1'b1, 1'b0, 1'b0);
      wait_n(5);
      check("pre_wrap", shown(), 24'h595999);
      wait_n(1);
      check("wrap_digits", shown(), 24'h000000);
      check("wrap_ovf", {23'd0, bus.overflow}, 24'd1);
      check("wrap_running", {23'd0, bus.running}, 24'd1);
      wait_n(37);
      check("post_wrap", shown(), 24'h000003);
      press(1'b1, 1'b0, 1'b0);
      check("ovf_paused", {23'd0, bus.overflow}, 24'd1);
      press(1'b0, 1'b0, 1'b1);
      check("clr_digits", shown(), 24'h0);
      check("clr_ovf", {23'd0, bus.overflow}, 24'd0);
      check("clr_running", {23'd0, bus.running}, 24'd0);

      // Lap freeze at 00:01.23 and release at 00:01.73.
      press(1'b1, 1'b0, 1'b0);
      wait_n(1232);
      check("pre_lap", shown(), 24'h000123);
      press(1'b0, 1'b1, 1'b0);
      check("lap_snap", shown(), 24'h000123);
      check("lap_running", {23'd0, bus.running}, 24'd1);
      wait_n(497);
      check("lap_frozen", shown(), 24'h000123);
      press(1'b0, 1'b1, 1'b0);
      check("lap_release", shown(), 24'h000173);

      // Pause at 00:00.05 with prescaler 4; clear beats start_stop.
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      wait_n(50);
      press(1'b1, 1'b0, 1'b0);
      check("pause_005", shown(), 24'h000005);
      press(1'b1, 1'b0, 1'b1);
      check("clr_wins", shown(), 24'h0);
      check("clr_wins_run", {23'd0, bus.running}, 24'd0);
      wait_n(20);
      check("idle_stay", shown(), 24'h0);

      press(1'b1, 1'b0, 1'b0);
      wait_n(50);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      wait_n(5);
      check("resume_5", shown(), 24'h000005);
      wait_n(1);
      check("resume_tick", shown(), 24'h000006);

      // Clear ignored while running; held start_stop gives a single toggle.
      press(1'b0, 1'b0, 1'b1);
      wait_n(6);
      check("clr_ignored", shown(), 24'h000007);
      check("clr_ign_run", {23'd0, bus.running}, 24'd1);
      bus.start_stop = 1'b1;
      wait_n(50);
      bus.start_stop = 1'b0;
      wait_n(10);
      check("hold_single", {23'd0, bus.running}, 24'd0);
      check("hold_count", shown(), 24'h000007);

      // start_stop beats lap in RUN.
      press(1'b1, 1'b0, 1'b0);
      wait_n(3);
      press(1'b1, 1'b1, 1'b0);
      check("ss_beats_lap", {23'd0, bus.running}, 24'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Timekeeping core of the stopwatch; sits directly upstream of the seven-segment display multiplexer.
- Produces six 4-bit BCD digits (MM:SS.hh) on registered outputs that feed the multiplexer's digit inputs.
- Owns the run/pause/lap/clear control state machine.
- Derives a 1/TICK_HZ time base from the system clock with an internal prescaler.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 100, counting resolution in Hz (hundredths). DIV = CLK_HZ/TICK_HZ; must be an integer >= 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_stop  in  1  raw button level; each rising edge toggles run/stop.
- lap  in  1  raw button level; each rising edge toggles the frozen lap display.
- clear  in  1  raw button level; a rising edge zeroes the count when stopped.
- digit_0  out  4  hundredths units (0-9).
- digit_1  out  4  hundredths tens (0-9).
- digit_2  out  4  seconds units (0-9).
- digit_3  out  4  seconds tens (0-5).
- digit_4  out  4  minutes units (0-9).
- digit_5  out  4  minutes tens (0-5).
- running  out  1  high in RUN and LAP_RUN.
- overflow  out  1  sticky; set on wrap past 59:59.99.

Behaviour:
- Reset (async, active-high): all digits 0, running 0, overflow 0, prescaler 0, state IDLE, synchronizer/edge registers 0.
- Inputs: each button passes through a 2-FF synchronizer and then a registered edge detector.
  - A level rising before clock edge N produces a one-cycle pulse that is acted on at edge N+3.
  - Held levels produce exactly one pulse. No debounce (handled upstream).
- States:
  - IDLE: count zero, not counting. start_stop -> RUN.
  - RUN: counting, display live.
    - start_stop -> PAUSE.
    - lap -> LAP_RUN; display snapshot taken at that edge.
    - clear ignored.
  - LAP_RUN: counting continues internally; outputs hold the snapshot.
    - lap -> RUN; display live at next edge.
    - start_stop -> PAUSE; display live.
    - clear ignored.
  - PAUSE: not counting; prescaler holds its value (no truncation of partial tick).
    - start_stop -> RUN.
    - clear -> IDLE: zero digits, prescaler, overflow.
    - lap ignored.
- Simultaneous pulses in the same cycle:
  - In PAUSE, clear wins over start_stop.
  - In RUN or LAP_RUN, start_stop wins over lap.
- Prescaler:
  - Counts 0..DIV-1 in RUN/LAP_RUN and wraps to 0.
  - The tick fires on the cycle where the prescaler equals DIV-1.
  - The first tick after IDLE->RUN occurs DIV cycles after the transition edge.
- BCD cascade on tick:
  - digit_0 increments; 9 -> 0 carries to digit_1.
  - digit_1 9->0 carries to digit_2.
  - digit_2 9->0 carries to digit_3.
  - digit_3 5->0 carries to digit_4.
  - digit_4 9->0 carries to digit_5.
  - digit_5 5->0 is a full wrap: all digits become 0, overflow set, counting continues.
  - All carries resolve in the same edge; digits are never transiently non-BCD.
- Outputs:
  - All outputs registered; values in the range 0-9 only.
  - In LAP_RUN, the internal count and the output registers are separate.
- Reset mid-operation: immediate return to IDLE and all-zero outputs regardless of state or pending pulses.

Test Plan (CLK_HZ=1000, TICK_HZ=100, DIV=10):
1. Reset asserted mid-count, then released -> all digits 0, running=0, overflow=0 asynchronously; start_stop pulse -> running=1 at edge N+3, digit_0=1 exactly 10 cycles later.
2. Run 1000 ticks -> digits read 00:10.00 (digit_3=1, rest 0); check each carry boundary (09->10 hundredths, 59.99->1:00.00).
3. Preload by running to 59:59.99, one more tick -> all digits 0, overflow=1, running stays 1; overflow persists until a clear from PAUSE.
4. RUN at 00:01.23, lap pulse -> outputs frozen at 00:01.23 while 50 ticks elapse; second lap pulse -> outputs show 00:01.73 on the next edge.
5. Pause at 00:00.05 with prescaler=4, clear pulse asserted together with start_stop -> IDLE, all zero, running=0; start_stop alone from PAUSE (no clear) -> first tick after 6 cycles.
6. In RUN, clear pulse -> ignored, count continues; start_stop held high for 50 cycles -> single PAUSE transition only.
